// File: rtl/trig_rom_arbiter_if.sv
// Request, grant, ROM and response bundle shared by the two ship controllers,
// the trig ROM and the arbiter.
interface trig_rom_arbiter_if #(
   parameter int ANGLE_W = 8,
   parameter int DATA_W  = 20
);
   logic               req_p1;
   logic [ANGLE_W-1:0] angle_p1;
   logic               req_p2;
   logic [ANGLE_W-1:0] angle_p2;
   logic               gnt_p1;
   logic               gnt_p2;
   logic [ANGLE_W-1:0] rom_addr;
   logic               rom_rd;
   logic [DATA_W-1:0]  rom_q;
   logic               rsp_valid_p1;
   logic               rsp_valid_p2;
   logic [DATA_W-1:0]  rsp_data;
   logic               busy;

   modport slave (
      input  req_p1, angle_p1, req_p2, angle_p2, rom_q,
      output gnt_p1, gnt_p2, rom_addr, rom_rd,
             rsp_valid_p1, rsp_valid_p2, rsp_data, busy
   );

   modport master (
      output req_p1, angle_p1, req_p2, angle_p2, rom_q,
      input  gnt_p1, gnt_p2, rom_addr, rom_rd,
             rsp_valid_p1, rsp_valid_p2, rsp_data, busy
   );
endinterface

// File: rtl/trig_rom_arbiter.sv
// Two-requester round-robin front end for a shared synchronous trig ROM.
// Pipeline: S1 grant/issue, S2 ROM access, S3 tagged response.
module trig_rom_arbiter #(
   parameter int ANGLE_W = 8,
   parameter int DATA_W  = 20
) (
   input  logic               Clk,
   input  logic               Reset_n,
   trig_rom_arbiter_if.slave  bus
);

   logic               elig_p1;
   logic               elig_p2;
   logic               pick_p1;
   logic               pick_p2;

   logic               last_p1_q;
   logic               gnt_p1_q;
   logic               gnt_p2_q;
   logic [ANGLE_W-1:0] rom_addr_q;
   logic               s1_valid;

   logic               s2_valid_q;
   logic               s2_p2_q;

   logic               rsp_valid_p1_q;
   logic               rsp_valid_p2_q;
   logic [DATA_W-1:0]  rsp_data_q;

   // A requester granted this cycle still shows its held-over req; mask it so
   // the other side gets the next slot and a lone requester waits one cycle.
   always_comb begin
      elig_p1 = bus.req_p1 & ~gnt_p1_q;
      elig_p2 = bus.req_p2 & ~gnt_p2_q;
      pick_p1 = elig_p1 & (~elig_p2 | ~last_p1_q);
      pick_p2 = elig_p2 & ~pick_p1;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         gnt_p1_q   <= 1'b0;
         gnt_p2_q   <= 1'b0;
         rom_addr_q <= '0;
         last_p1_q  <= 1'b0;
      end else begin
         gnt_p1_q <= pick_p1;
         gnt_p2_q <= pick_p2;
         if (pick_p1) begin
            rom_addr_q <= bus.angle_p1;
         end else if (pick_p2) begin
            rom_addr_q <= bus.angle_p2;
         end
         if (pick_p1 | pick_p2) begin
            last_p1_q <= pick_p1;
         end
      end
   end

   assign s1_valid = gnt_p1_q | gnt_p2_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s2_valid_q <= 1'b0;
         s2_p2_q    <= 1'b0;
      end else begin
         s2_valid_q <= s1_valid;
         s2_p2_q    <= gnt_p2_q;
      end
   end

   // rom_q is valid during S2, so it is captured at the edge leaving S2.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rsp_valid_p1_q <= 1'b0;
         rsp_valid_p2_q <= 1'b0;
         rsp_data_q     <= '0;
      end else begin
         rsp_valid_p1_q <= s2_valid_q & ~s2_p2_q;
         rsp_valid_p2_q <= s2_valid_q &  s2_p2_q;
         if (s2_valid_q) begin
            rsp_data_q <= bus.rom_q;
         end
      end
   end

   assign bus.gnt_p1       = gnt_p1_q;
   assign bus.gnt_p2       = gnt_p2_q;
   assign bus.rom_rd       = s1_valid;
   assign bus.rom_addr     = rom_addr_q;
   assign bus.rsp_valid_p1 = rsp_valid_p1_q;
   assign bus.rsp_valid_p2 = rsp_valid_p2_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.busy         = s1_valid | s2_valid_q | rsp_valid_p1_q | rsp_valid_p2_q;

   a_one_grant : assert property (@(posedge Clk) disable iff (!Reset_n)
      !(gnt_p1_q && gnt_p2_q));

endmodule

// File: doc/trig_rom_arbiter.md
TRIG_ROM_ARBITER -- requirements
Module: trig_rom_arbiter

Interface
REQ-001 Parameter ANGLE_W, default 8, width of the heading angle and ROM address.
REQ-002 Parameter DATA_W, default 20, width of the ROM word (packed sin/cos step pair).
REQ-003 Clk  input  1  system clock; all state changes on rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_p1  input  1  player-1 ship controller lookup request, level, held until granted.
REQ-006 angle_p1  input  ANGLE_W  player-1 lookup angle, valid while req_p1 high.
REQ-007 req_p2  input  1  player-2 lookup request, same rules as req_p1.
REQ-008 angle_p2  input  ANGLE_W  player-2 lookup angle.
REQ-009 gnt_p1  output  1  one-cycle pulse: player-1 request accepted, angle captured.
REQ-010 gnt_p2  output  1  one-cycle pulse: player-2 request accepted.
REQ-011 rom_addr  output  ANGLE_W  registered address to shared synchronous trig ROM.
REQ-012 rom_rd  output  1  registered ROM read strobe, high in the cycle rom_addr is valid.
REQ-013 rom_q  input  DATA_W  ROM data, valid exactly one cycle after rom_rd.
REQ-014 rsp_valid_p1  output  1  one-cycle pulse: rsp_data belongs to player 1.
REQ-015 rsp_valid_p2  output  1  one-cycle pulse: rsp_data belongs to player 2.
REQ-016 rsp_data  output  DATA_W  registered lookup result, shared by both requesters.
REQ-017 busy  output  1  high while any pipeline stage holds an in-flight lookup.

Function
REQ-018 The block SHALL be a three-stage pipeline: arbitrate/issue (S1), ROM read (S2), response (S3).
REQ-019 Request sampled at edge ending cycle N SHALL produce gnt, rom_rd and rom_addr=captured angle in cycle N+1.
REQ-020 rom_q SHALL be captured at edge ending cycle N+2; rsp_valid_px and rsp_data SHALL be valid in cycle N+3 (latency 3).
REQ-021 At most one grant SHALL be issued per cycle; gnt_p1 and gnt_p2 SHALL never be high together.
REQ-022 A requester whose gnt is high in cycle M SHALL be ineligible at the edge ending cycle M (masks held-over req).
REQ-023 Sole eligible requester SHALL be granted.
REQ-024 Both eligible: grant the requester not granted most recently (round-robin pointer).
REQ-025 Round-robin pointer SHALL update only on a grant; idle cycles leave it unchanged.
REQ-026 No eligible request: gnt_p1=gnt_p2=0, rom_rd=0, rom_addr holds last value.
REQ-027 Both requesters held high continuously SHALL yield one grant every cycle, alternating P1/P2.
REQ-028 A single requester held high SHALL be granted every second cycle.
REQ-029 rsp_valid_px SHALL carry the ID tag of the grant that issued the read; responses return in issue order.
REQ-030 rsp_data SHALL hold its last value when no rsp_valid is high.
REQ-031 busy = OR of S1, S2, S3 valid bits.
REQ-032 Angle changes while req is held but before grant SHALL be honoured; the value sampled at the granting edge is used.

Reset
REQ-033 Reset_n low SHALL immediately clear gnt_p1, gnt_p2, rom_rd, rsp_valid_p1, rsp_valid_p2, busy, all stage valid bits, rom_addr=0, rsp_data=0.
REQ-034 Round-robin pointer SHALL reset to "P2 last", so P1 wins the first simultaneous request.
REQ-035 Lookups in flight at reset SHALL be discarded; no rsp_valid for them after Reset_n rises.
REQ-036 Requests SHALL be sampled from the first rising edge with Reset_n high.

Verification
REQ-037 Reset_n low with both req high -> all outputs 0 throughout, busy=0.
REQ-038 req_p1=1, angle_p1=0x10 sampled cycle 0, dropped on gnt -> gnt_p1 cycle 1, rom_addr=0x10 rom_rd=1 cycle 1, ROM returns 0x0ABCD cycle 2 -> rsp_valid_p1=1, rsp_data=0x0ABCD cycle 3, busy low cycle 4.
REQ-039 First request after reset: req_p1 and req_p2 together (angles 0x20, 0x40) -> gnt_p1 cycle 1 (addr 0x20), gnt_p2 cycle 2 (addr 0x40); rsp_valid_p1 cycle 3, rsp_valid_p2 cycle 4.
REQ-040 Both req held 8 cycles -> grants P1,P2,P1,P2,... every cycle, no gap, no double grant.
REQ-041 req_p1 held alone 6 cycles -> gnt_p1 in cycles 1, 3, 5 only.
REQ-042 Reset_n pulsed low in cycle 2 after grant in cycle 1 -> no rsp_valid_p1 in cycle 3 or later; next request after release served normally.
